// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and mux selects.
// UART_TX_FSM_TWO_STOP_EN adds the STOP2 state to the encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
`ifdef UART_TX_FSM_TWO_STOP_EN
    STOP   = 3'd4,
    STOP2  = 3'd5
`else
    STOP   = 3'd4
`endif
  } state_e;

  // Transmit mux selects; also consumed by the output mux and the testbench.
  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_STOP   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

endpackage

// File: rtl/uart_bit_counter.sv
// Counts data bits 0..DATA_WIDTH-1 while enabled; done flags the last bit.
// Wraps to zero after the last bit so the counter is clean for the next frame.
module uart_bit_counter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic done
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      if (cnt_reg == LAST) cnt_reg <= '0;
      else                 cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign done = (cnt_reg == LAST);

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: start, DATA_WIDTH data bits, optional parity, stop.
// Define UART_TX_FSM_TWO_STOP_EN to end every frame with two stop cycles.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic       par_en,
  output logic       ser_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;
`ifdef UART_TX_FSM_TWO_STOP_EN
  localparam logic [2:0] ST_STOP2  = STOP2;
  localparam logic [2:0] ST_LAST   = ST_STOP2;
`else
  localparam logic [2:0] ST_LAST   = ST_STOP;
`endif

  logic [2:0] state_reg;
  logic [2:0] state_next;
  logic       par_reg;
  logic       accept;
  logic       bit_done;

  // Requests are taken in IDLE or in the final stop cycle so frames can abut.
  assign accept   = data_valid && !rst && (state_reg == ST_IDLE || state_reg == ST_LAST);
  assign ser_load = accept;

  uart_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .enable (state_reg == ST_DATA),
    .clear  (state_reg != ST_DATA),
    .done   (bit_done)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = ST_START;
      ST_START:  state_next = ST_DATA;
      ST_DATA:   if (bit_done) state_next = par_reg ? ST_PARITY : ST_STOP;
      ST_PARITY: state_next = ST_STOP;
`ifdef UART_TX_FSM_TWO_STOP_EN
      ST_STOP:   state_next = ST_STOP2;
      ST_STOP2:  state_next = accept ? ST_START : ST_IDLE;
`else
      ST_STOP:   state_next = accept ? ST_START : ST_IDLE;
`endif
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      par_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) par_reg <= par_en;
    end
  end

  always_comb begin
    mux_sel = SEL_STOP;
    busy    = 1'b0;
    ser_en  = 1'b0;
    case (state_reg)
      ST_START: begin
        mux_sel = SEL_START;
        busy    = 1'b1;
      end
      ST_DATA: begin
        mux_sel = SEL_DATA;
        busy    = 1'b1;
        ser_en  = 1'b1;
      end
      ST_PARITY: begin
        mux_sel = SEL_PARITY;
        busy    = 1'b1;
      end
`ifdef UART_TX_FSM_TWO_STOP_EN
      ST_STOP, ST_STOP2: begin
`else
      ST_STOP: begin
`endif
        mux_sel = SEL_STOP;
        busy    = 1'b1;
      end
      default: begin
        mux_sel = SEL_STOP;
        busy    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm against a queue-of-bit-slots frame model.
// Build with UART_TX_FSM_TWO_STOP_EN to check the two-stop-cycle variant.
`timescale 1ns/1ps
module tb_uart_tx_fsm;
  import uart_pkg::*;

  localparam int W = 8;
`ifdef UART_TX_FSM_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       data_valid;
  logic       par_en;
  logic       ser_load;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_frames = 0;

  logic [1:0] model_q[$];
  logic [1:0] exp_mux, act_mux;
  logic       exp_busy, act_busy, exp_sen, act_sen, exp_load, act_load;

  uart_tx_fsm #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .par_en     (par_en),
    .ser_load   (ser_load),
    .ser_en     (ser_en),
    .mux_sel    (mux_sel),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic int frame_len(input logic pe);
    return 1 + W + int'(pe) + NSTOP;
  endfunction

  // One clock cycle: drive inputs, sample at the falling edge, advance the model.
  // The model is a queue of remaining bit slots; the last slot is the final stop.
  task automatic tick(input logic dv, input logic pe);
    logic acc;
    data_valid = dv;
    par_en     = pe;
    @(negedge clk);
    act_mux  = mux_sel;
    act_busy = busy;
    act_sen  = ser_en;
    act_load = ser_load;
    exp_busy = (model_q.size() != 0);
    exp_mux  = SEL_STOP;
    exp_sen  = 1'b0;
    if (exp_busy) begin
      exp_mux = model_q[0];
      exp_sen = (model_q[0] == SEL_DATA);
    end
    acc      = dv && (model_q.size() <= 1);
    exp_load = acc;
    if (model_q.size() != 0) void'(model_q.pop_front());
    if (acc) begin
      n_frames++;
      $display("cycle %0d: frame %0d accepted par_en=%0d", cyc, n_frames, pe);
      model_q.push_back(SEL_START);
      for (int i = 0; i < W; i++) model_q.push_back(SEL_DATA);
      if (pe) model_q.push_back(SEL_PARITY);
      for (int i = 0; i < NSTOP; i++) model_q.push_back(SEL_STOP);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; data_valid = 1'b1; par_en = 1'b1;
    #2;
    checks++;
    if ({mux_sel, busy, ser_en, ser_load} !== {SEL_STOP, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got mux=%b busy=%b ser_en=%b ser_load=%b, want mux=01 busy=0 ser_en=0 ser_load=0",
               mux_sel, busy, ser_en, ser_load);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; data_valid = 1'b0; par_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if ({act_mux, act_busy, act_sen, act_load} !== {exp_mux, exp_busy, exp_sen, exp_load}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", cyc,
                 act_mux, act_busy, act_sen, act_load, exp_mux, exp_busy, exp_sen, exp_load);
      end
    end
  endtask

  task automatic test_single_frame();
    int busy_cnt = 0;
    int load_cnt = 0;
    for (int i = 0; i < frame_len(1'b0) + 4; i++) begin
      tick(i == 0, 1'b0);
      busy_cnt += int'(act_busy);
      load_cnt += int'(act_load);
      checks++;
      if ({act_mux, act_busy, act_sen, act_load} !== {exp_mux, exp_busy, exp_sen, exp_load}) begin
        errors++;
        $display("FAIL single_frame cyc=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", cyc,
                 act_mux, act_busy, act_sen, act_load, exp_mux, exp_busy, exp_sen, exp_load);
      end
    end
    checks++;
    if (busy_cnt != frame_len(1'b0) || load_cnt != 1) begin
      errors++;
      $display("FAIL single_frame_len: busy=%0d loads=%0d want busy=%0d loads=1",
               busy_cnt, load_cnt, frame_len(1'b0));
    end
  endtask

  task automatic test_parity();
    int busy_cnt = 0;
    int par_cnt  = 0;
    for (int i = 0; i < frame_len(1'b1) + 3; i++) begin
      tick(i == 0, i < 2);
      busy_cnt += int'(act_busy);
      par_cnt  += int'(act_mux == SEL_PARITY);
      checks++;
      if ({act_mux, act_busy, act_sen, act_load} !== {exp_mux, exp_busy, exp_sen, exp_load}) begin
        errors++;
        $display("FAIL parity cyc=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", cyc,
                 act_mux, act_busy, act_sen, act_load, exp_mux, exp_busy, exp_sen, exp_load);
      end
    end
    checks++;
    if (busy_cnt != frame_len(1'b1) || par_cnt != 1) begin
      errors++;
      $display("FAIL parity_len: busy=%0d parity_cycles=%0d want busy=%0d parity_cycles=1",
               busy_cnt, par_cnt, frame_len(1'b1));
    end
  endtask

  task automatic test_back_to_back();
    int loads = 0;
    int last_load = -1;
    int gap_bad = 0;
    int busy_drop = 0;
    for (int i = 0; i < 3 * frame_len(1'b0) + 4; i++) begin
      tick(loads < 3, 1'b0);
      if (act_load) begin
        if (last_load >= 0 && cyc - last_load != frame_len(1'b0)) gap_bad++;
        last_load = cyc;
        loads++;
      end
      if (i > 0 && i <= 3 * frame_len(1'b0) && !act_busy) busy_drop++;
      checks++;
      if ({act_mux, act_busy, act_sen, act_load} !== {exp_mux, exp_busy, exp_sen, exp_load}) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", cyc,
                 act_mux, act_busy, act_sen, act_load, exp_mux, exp_busy, exp_sen, exp_load);
      end
    end
    checks++;
    if (loads != 3 || gap_bad != 0 || busy_drop != 0) begin
      errors++;
      $display("FAIL back_to_back_spacing: loads=%0d bad_gaps=%0d busy_drops=%0d want 3/0/0",
               loads, gap_bad, busy_drop);
    end
  endtask

  task automatic test_ignore_busy();
    int load_cnt = 0;
    for (int i = 0; i < frame_len(1'b0) + 2; i++) begin
      tick(i == 0 || i == 3 || i == 5 || i == 7, 1'b0);
      load_cnt += int'(act_load);
      checks++;
      if ({act_mux, act_busy, act_sen, act_load} !== {exp_mux, exp_busy, exp_sen, exp_load}) begin
        errors++;
        $display("FAIL ignore_busy cyc=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", cyc,
                 act_mux, act_busy, act_sen, act_load, exp_mux, exp_busy, exp_sen, exp_load);
      end
    end
    checks++;
    if (load_cnt != 1) begin
      errors++;
      $display("FAIL ignore_busy_loads: got %0d loads want 1", load_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    // Accept, START, then three data cycles: the bench then sits in the 4th data cycle.
    for (int i = 0; i < 5; i++) tick(i == 0, 1'b0);
    rst = 1'b1;
    data_valid = 1'b1;
    #1;
    checks++;
    if ({mux_sel, busy, ser_en, ser_load} !== {SEL_STOP, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_midframe: got mux=%b busy=%b ser_en=%b ser_load=%b, want mux=01 busy=0 ser_en=0 ser_load=0",
               mux_sel, busy, ser_en, ser_load);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    data_valid = 1'b0;
    model_q.delete();
    for (int i = 0; i < frame_len(1'b1) + 3; i++) begin
      tick(i == 1, 1'b1);
      checks++;
      if ({act_mux, act_busy, act_sen, act_load} !== {exp_mux, exp_busy, exp_sen, exp_load}) begin
        errors++;
        $display("FAIL post_reset_frame cyc=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", cyc,
                 act_mux, act_busy, act_sen, act_load, exp_mux, exp_busy, exp_sen, exp_load);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      checks++;
      if ({act_mux, act_busy, act_sen, act_load} !== {exp_mux, exp_busy, exp_sen, exp_load}) begin
        errors++;
        $display("FAIL random cyc=%0d: got %b/%b/%b/%b want %b/%b/%b/%b", cyc,
                 act_mux, act_busy, act_sen, act_load, exp_mux, exp_busy, exp_sen, exp_load);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_ignore_busy();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
